// File: rtl/mult2_seq_ctrl_if.sv
// Request/result handshake between a datapath and the sequential 2x2-digit multiplier.
// The requester drives start/a/b and watches busy/done/product.
interface mult2_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/mult2_seq_ctrl.sv
// Unsigned WIDTH x WIDTH multiplier that walks 2-bit digit pairs through one
// gate-level 2x2 cell, one pair per cycle, shifting and accumulating partial products.
module mult2_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mult2_seq_ctrl_if.slave  bus
);

  localparam int D     = WIDTH / 2;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [IDX_W-1:0]  i_q;
  logic [IDX_W-1:0]  j_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     product_q;
  logic              done_q;

  // Digit pair currently presented to the cell; sourced only from registers.
  logic [1:0]        a_dig;
  logic [1:0]        b_dig;
  assign a_dig = 2'(a_r >> {i_q, 1'b0});
  assign b_dig = 2'(b_r >> {j_q, 1'b0});

  // 2x2 gate-level multiplier cell: two half adders combine the AND terms.
  logic c0, c1, c2, c3;
  logic p1, p2, p3, k1;
  assign c0 = a_dig[0] & b_dig[0];
  assign p1 = a_dig[1] & b_dig[0];
  assign p2 = a_dig[0] & b_dig[1];
  assign p3 = a_dig[1] & b_dig[1];
  assign c1 = p1 ^ p2;
  assign k1 = p1 & p2;
  assign c2 = p3 ^ k1;
  assign c3 = p3 & k1;

  logic [3:0]        pp;
  logic [IDX_W:0]    dsum;
  logic [IDX_W+1:0]  shamt;
  logic [PW-1:0]     term;
  logic              last_pair;

  assign pp        = {c3, c2, c1, c0};
  assign dsum      = {1'b0, i_q} + {1'b0, j_q};
  assign shamt     = {dsum, 1'b0};
  assign term      = PW'(pp) << shamt;
  assign last_pair = (i_q == LAST) && (j_q == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_pair) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r       <= '0;
      b_r       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_q + term;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        DONE:    product_q <= acc_q;
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult2_seq_ctrl.sv
// Directed bench for mult2_seq_ctrl at WIDTH=8 and WIDTH=2: latency, busy span,
// start filtering, back-to-back operation, mid-run reset and exhaustive 2-bit products.
module tb_mult2_seq_ctrl;

  logic clk;
  logic rst_n;

  mult2_seq_ctrl_if #(.WIDTH(8)) m8 ();
  mult2_seq_ctrl_if #(.WIDTH(2)) m2 ();

  mult2_seq_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(m8));
  mult2_seq_ctrl #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(m2));

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic wait8(output int lat, inout int bc);
    lat = 0;
    do begin
      tick();
      lat++;
      if (m8.busy === 1'b1) bc++;
    end while (m8.done !== 1'b1 && lat < 60);
  endtask

  task automatic wait2(output int lat, inout int bc);
    lat = 0;
    do begin
      tick();
      lat++;
      if (m2.busy === 1'b1) bc++;
    end while (m2.done !== 1'b1 && lat < 20);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                     input string tag);
    int lat;
    int bc;
    m8.a = a; m8.b = b; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    bc = (m8.busy === 1'b1) ? 1 : 0;
    wait8(lat, bc);
    check({tag, "_latency"}, lat, 17);
    check({tag, "_busy_cycles"}, bc, 17);
    check({tag, "_product"}, m8.product, exp);
    tick();
    check({tag, "_done_pulse_width"}, m8.done, 0);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic [3:0] exp,
                     input string tag);
    int lat;
    int bc;
    m2.a = a; m2.b = b; m2.start = 1'b1;
    tick();
    m2.start = 1'b0;
    bc = (m2.busy === 1'b1) ? 1 : 0;
    wait2(lat, bc);
    check({tag, "_latency"}, lat, 2);
    check({tag, "_busy_cycles"}, bc, 2);
    check({tag, "_product"}, m2.product, exp);
    tick();
    check({tag, "_done_pulse_width"}, m2.done, 0);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;

    rst_n = 1'b0;
    m8.start = 1'b0; m8.a = '0; m8.b = '0;
    m2.start = 1'b0; m2.a = '0; m2.b = '0;
    tick();
    tick();
    check("rst_busy8", m8.busy, 0);
    check("rst_done8", m8.done, 0);
    check("rst_product8", m8.product, 0);
    check("rst_busy2", m2.busy, 0);
    check("rst_product2", m2.product, 0);
    rst_n = 1'b1;
    tick();

    // Zero operands still run the full digit sweep.
    op8(8'd0, 8'd0, 16'h0000, "zero");
    check("zero_idle_after", m8.busy, 0);

    op8(8'd13, 8'd11, 16'd143, "13x11");
    seen = 0;
    repeat (20) begin
      tick();
      if (m8.done === 1'b1) seen++;
      check("13x11_hold", m8.product, 143);
    end
    check("13x11_no_extra_done", seen, 0);

    op8(8'd255, 8'd255, 16'hFE01, "255x255");

    // Start during RUN is ignored; restart in the done cycle is accepted.
    m8.a = 8'd200; m8.b = 8'd3; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    repeat (4) tick();
    m8.a = 8'd7; m8.b = 8'd7; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    bc = 0;
    wait8(lat, bc);
    check("ignore_latency", lat, 12);
    check("ignore_product", m8.product, 16'd600);
    m8.a = 8'd7; m8.b = 8'd7; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    check("b2b_accepted_busy", m8.busy, 1);
    check("b2b_old_product", m8.product, 16'd600);
    bc = 1;
    wait8(lat, bc);
    check("b2b_latency", lat, 17);
    check("b2b_product", m8.product, 16'd49);
    tick();

    // Reset abandons a run in progress.
    m8.a = 8'd100; m8.b = 8'd100; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", m8.busy, 0);
    check("midrst_done", m8.done, 0);
    check("midrst_product", m8.product, 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (m8.done === 1'b1) seen++;
    end
    check("midrst_no_done", seen, 0);
    op8(8'd2, 8'd3, 16'd6, "post_rst");

    // Single-digit configuration.
    op2(2'd3, 2'd3, 4'b1001, "w2_3x3");
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        op2(2'(x), 2'(y), 4'(x * y), $sformatf("w2_%0dx%0d", x, y));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
